// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit owning the architectural HI/LO registers.
// MULTU/DIVU take 32 one-bit iterations; MTHI/MTLO and divide-by-zero finish in one cycle.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic             busy_q;
   logic             done_q;
   logic             divzero_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH:0]   mul_sum_d;
   logic [WIDTH:0]   mul_acc_d;
   logic [WIDTH-1:0] mul_q_d;
   logic [WIDTH:0]   div_rem_d;
   logic [WIDTH-1:0] div_shq_d;
   logic [WIDTH:0]   div_diff_d;
   logic [WIDTH:0]   div_acc_d;
   logic [WIDTH-1:0] div_q_d;
   logic             last_iter;

   assign last_iter = (cnt_q == CNT_LAST);

   always_comb begin
      // acc_q[WIDTH] is always zero while multiplying, so adding the full acc is exact.
      mul_sum_d = acc_q + (q_q[0] ? {1'b0, d_q} : {(WIDTH + 1){1'b0}});
      mul_acc_d = {1'b0, mul_sum_d[WIDTH:1]};
      mul_q_d   = {mul_sum_d[0], q_q[WIDTH-1:1]};

      div_rem_d  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      div_shq_d  = {q_q[WIDTH-2:0], 1'b0};
      div_diff_d = div_rem_d - {1'b0, d_q};
      // Partial remainder stays below 2*d, so the top bit of the difference is the borrow.
      if (!div_diff_d[WIDTH]) begin
         div_acc_d = div_diff_d;
         div_q_d   = div_shq_d | {{(WIDTH - 1){1'b0}}, 1'b1};
      end else begin
         div_acc_d = div_rem_d;
         div_q_d   = div_shq_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         d_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !flush) begin
                  case (op)
                     OP_MTHI: begin
                        hi_q   <= a;
                        done_q <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo_q   <= a;
                        done_q <= 1'b1;
                     end
                     OP_MULTU: begin
                        acc_q   <= '0;
                        q_q     <= a;
                        d_q     <= b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MUL;
                     end
                     default: begin
                        if (b == '0) begin
                           hi_q      <= a;
                           lo_q      <= '1;
                           done_q    <= 1'b1;
                           divzero_q <= 1'b1;
                        end else begin
                           acc_q   <= '0;
                           q_q     <= a;
                           d_q     <= b;
                           cnt_q   <= '0;
                           busy_q  <= 1'b1;
                           state_q <= S_DIV;
                        end
                     end
                  endcase
               end
            end
            S_MUL: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= mul_acc_d;
                  q_q   <= mul_q_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_iter) begin
                     hi_q    <= mul_acc_d[WIDTH-1:0];
                     lo_q    <= mul_q_d;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DIV: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= div_acc_d;
                  q_q   <= div_q_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_iter) begin
                     hi_q    <= div_acc_d[WIDTH-1:0];
                     lo_q    <= div_q_d;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign divzero = divzero_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops checked
// against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_DIVU  = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic        divzero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .divzero (divzero),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, follow it to completion and compare against the arithmetic model.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] prod;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dz;
      logic        multi;
      int          cycles;
      exp_hi = model_hi;
      exp_lo = model_lo;
      exp_dz = 1'b0;
      multi  = 1'b0;
      case (o)
         OP_MULTU: begin
            prod   = 64'(x) * 64'(y);
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
            multi  = 1'b1;
         end
         OP_DIVU: begin
            if (y == 0) begin
               exp_hi = x;
               exp_lo = 32'hFFFF_FFFF;
               exp_dz = 1'b1;
            end else begin
               exp_hi = x % y;
               exp_lo = x / y;
               multi  = 1'b1;
            end
         end
         OP_MTHI: exp_hi = x;
         default: exp_lo = x;
      endcase

      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
      if (multi) begin
         check("hold_hi_busy", hi, model_hi);
         check("hold_lo_busy", lo, model_lo);
         cycles = 0;
         while (busy && cycles < 40) begin
            check("done_in_busy", done, 0);
            cycles++;
            tick();
         end
         check("busy_cycles", cycles, 32);
      end else begin
         check("busy_single", busy, 0);
      end
      check("done_pulse", done, 1);
      check("divzero", divzero, exp_dz);
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b (exp hi=%h lo=%h)",
               o, x, y, hi, lo, divzero, exp_hi, exp_lo);
      model_hi = exp_hi;
      model_lo = exp_lo;
      tick();
      check("done_one_cycle", done, 0);
      check("divzero_one_cycle", divzero, 0);
   endtask

   initial begin
      int          cycles;
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;

      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      #12;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_divzero", divzero, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_hi", hi, 0);
      end

      run_op(OP_MTHI, 32'h1111_2222, 32'h0);
      run_op(OP_MTLO, 32'h3333_4444, 32'h0);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(OP_DIVU, 32'd100, 32'd7);
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
      run_op(OP_DIVU, 32'h0000_1234, 32'd0);
      run_op(OP_MULTU, 32'd0, 32'hFFFF_FFFF);
      run_op(OP_DIVU, 32'd5, 32'hFFFF_FFFF);

      // Flush on the 10th busy cycle with a colliding start.
      run_op(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
      start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
      tick();
      start = 1'b0;
      check("flush_busy_before", busy, 1);
      repeat (9) tick();
      flush = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
      tick();
      flush = 1'b0; start = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_done", done, 0);
      check("flush_hi", hi, model_hi);
      check("flush_lo", lo, model_lo);
      tick();
      check("flush_start_drop", busy, 0);
      check("flush_no_done", done, 0);
      $display("flush mid-MULTU -> busy=%0b hi=%h", busy, hi);
      run_op(OP_MULTU, 32'd3, 32'd5);

      // Flush in IDLE beats start.
      start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hCAFE_0000;
      tick();
      start = 1'b0; flush = 1'b0;
      check("idle_flush_done", done, 0);
      check("idle_flush_hi", hi, model_hi);
      $display("idle flush+MTHI -> hi=%h done=%0b", hi, done);

      // start held high for 40 cycles.
      start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
      tick();
      cycles = 0;
      while (busy && cycles < 40) begin
         check("held_done_in_busy", done, 0);
         cycles++;
         tick();
      end
      check("held_busy_cycles", cycles, 32);
      check("held_done", done, 1);
      check("held_lo", lo, 6);
      check("held_hi", hi, 0);
      tick();
      check("held_reaccept", busy, 1);
      check("held_done_clear", done, 0);
      repeat (6) tick();
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 40) begin
         cycles++;
         tick();
      end
      check("held2_done", done, 1);
      check("held2_lo", lo, 6);
      $display("held start MULTU 2x3 -> hi=%h lo=%h", hi, lo);
      model_hi = 32'd0;
      model_lo = 32'd6;
      tick();

      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         case ($urandom_range(0, 3))
            0:       ry = (ro == OP_DIVU) ? 32'd0 : $urandom;
            1:       ry = $urandom_range(1, 20);
            default: ry = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) rx = $urandom_range(0, 300);
         run_op(ro, rx, ry);
      end

      // Asynchronous reset in the middle of a MULTU.
      run_op(OP_MTLO, 32'hA5A5_0001, 32'h0);
      start = 1'b1; op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_hi", hi, 0);
      check("async_rst_lo", lo, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      $display("async reset mid-MULTU -> busy=%0b hi=%h lo=%h", busy, hi, lo);
      model_hi = '0;
      model_lo = '0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_busy", busy, 0);
         check("post_rst_lo", lo, 0);
      end
      run_op(OP_DIVU, 32'd100, 32'd7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
